// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multi-cycle stage sequencer for the MUSA core. Walks one
//               instruction at a time through FETCH/DECODE/EXEC/MEM/WB,
//               issuing per-stage enable strobes, with memory handshakes,
//               external stall, halt/resume and a data-memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       fnction,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             cond_flag,
  input  logic             stall,
  input  logic             resume,
  output logic [2:0]       stage,
  output logic             imem_req,
  output logic             ir_en,
  output logic             rf_rd_en,
  output logic             alu_en,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_wr_en,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_HALTED = 3'b111
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BRFL    = 6'b010001;
  localparam logic [5:0] OP_JR      = 6'b000010;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       fn_q, fn_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Instruction class of the latched instruction; anything unrecognised
  // falls through as a NOP because none of the other classes claims it.
  logic is_alu, is_load, is_store, is_branch, is_jump, is_halt, is_nop;

  // Classify the latched opcode/function pair.
  always_comb begin
    is_alu    = ((op_q == OP_SPECIAL) && (fn_q != 6'b000000)) ||
                (op_q == OP_ADDI) || (op_q == OP_ANDI) || (op_q == OP_ORI);
    is_load   = (op_q == OP_LW);
    is_store  = (op_q == OP_SW);
    is_branch = (op_q == OP_BRFL);
    is_jump   = (op_q == OP_JR);
    is_halt   = (op_q == OP_HALT);
    is_nop    = !(is_alu || is_load || is_store || is_branch || is_jump || is_halt);
  end

  // Next-state and strobe decode; a stall freezes everything and silences strobes.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fn_d      = fn_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    ir_en     = 1'b0;
    rf_rd_en  = 1'b0;
    alu_en    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_wr_en  = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;

    if (!stall) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_en   = 1'b1;
            op_d    = opcode;
            fn_d    = fnction;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          rf_rd_en = 1'b1;
          if (is_halt) begin
            state_d = S_HALTED;
          end else if (is_nop) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_en = 1'b1;
          if (is_load || is_store) begin
            tmo_d   = '0;
            state_d = S_MEM;
          end else if (is_branch) begin
            pc_en   = 1'b1;
            pc_sel  = cond_flag;
            state_d = S_FETCH;
          end else if (is_jump) begin
            pc_en   = 1'b1;
            pc_sel  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          // A completing access wins over a timeout landing in the same cycle.
          if (dmem_ready) begin
            if (is_store) begin
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (tmo_q == TMO_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_HALTED;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_WB: begin
          rf_wr_en = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_FETCH;
        end
        S_HALTED: begin
          if (resume) begin
            state_d = S_FETCH;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end

    // Every PC update marks the end of exactly one retired instruction.
    if (pc_en) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // State and bookkeeping registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  assign stage   = state_q;
  assign halted  = (state_q == S_HALTED);
  assign err     = err_q;
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Self-checking bench for multicycle_sequencer. A table-driven
//               stage-path model is compared against the DUT every cycle,
//               backed by directed scenarios with literal expectations and a
//               randomized stimulus phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

  localparam int TMO_W       = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       fnction = '0;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             cond_flag = 1'b0;
  logic             stall = 1'b0;
  logic             resume = 1'b0;
  logic [2:0]       stage;
  logic             imem_req, ir_en, rf_rd_en, alu_en, dmem_req, dmem_we;
  logic             rf_wr_en, pc_en, pc_sel, halted, err;
  logic [CNT_W-1:0] retired;

  multicycle_sequencer #(
    .TMO_W(TMO_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .fnction(fnction),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .cond_flag(cond_flag),
    .stall(stall), .resume(resume), .stage(stage), .imem_req(imem_req),
    .ir_en(ir_en), .rf_rd_en(rf_rd_en), .alu_en(alu_en), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .rf_wr_en(rf_wr_en), .pc_en(pc_en), .pc_sel(pc_sel),
    .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: each class is a list of stages -------
  localparam int C_ALU = 0, C_NOP = 1, C_LOAD = 2, C_STORE = 3;
  localparam int C_BR = 4, C_JMP = 5, C_HALT = 6;

  int path_len [7]    = '{4, 2, 5, 4, 3, 3, 2};
  int path_stg [7][5] = '{'{0,1,2,4,0}, '{0,1,0,0,0}, '{0,1,2,3,4}, '{0,1,2,3,0},
                          '{0,1,2,0,0}, '{0,1,2,0,0}, '{0,1,0,0,0}};

  int          m_cls = C_NOP;
  int          m_idx = 0;
  int          m_tmo = 0;
  bit          m_halted = 1'b0;
  bit          m_err = 1'b0;
  int unsigned m_ret = 0;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:               return (fn == 6'h00) ? C_NOP : C_ALU;
      6'h08, 6'h0C, 6'h0D: return C_ALU;
      6'h23:               return C_LOAD;
      6'h2B:               return C_STORE;
      6'h11:               return C_BR;
      6'h02:               return C_JMP;
      6'h3F:               return C_HALT;
      default:             return C_NOP;
    endcase
  endfunction

  // Per-cycle comparison against the model, then advance the model one clock.
  always @(negedge clk) begin : cmp
    int st;
    bit run, last, e_pcen;
    if (!rst_n) begin
      m_cls = C_NOP; m_idx = 0; m_tmo = 0;
      m_halted = 1'b0; m_err = 1'b0; m_ret = 0;
    end
    st   = m_halted ? 7 : path_stg[m_cls][m_idx];
    run  = !stall;
    last = !m_halted && (m_idx > 0) && (m_idx == path_len[m_cls] - 1) && (m_cls != C_HALT);
    e_pcen = run && last && ((st != 3) || dmem_ready);
    chk("stage",    stage,    st);
    chk("imem_req", imem_req, run && st == 0);
    chk("ir_en",    ir_en,    run && st == 0 && imem_ready);
    chk("rf_rd_en", rf_rd_en, run && st == 1);
    chk("alu_en",   alu_en,   run && st == 2);
    chk("dmem_req", dmem_req, run && st == 3);
    chk("dmem_we",  dmem_we,  run && st == 3 && m_cls == C_STORE);
    chk("rf_wr_en", rf_wr_en, run && st == 4);
    chk("pc_en",    pc_en,    e_pcen);
    chk("pc_sel",   pc_sel,   e_pcen && (m_cls == C_JMP || (m_cls == C_BR && cond_flag)));
    chk("halted",   halted,   m_halted);
    chk("err",      err,      m_err);
    chk("retired",  retired,  m_ret & 32'hFFFF);
    if (rst_n && run) begin
      if (m_halted) begin
        if (resume) begin m_halted = 1'b0; m_idx = 0; end
      end else if (st == 0) begin
        if (imem_ready) begin m_cls = classify(opcode, fnction); m_idx = 1; end
      end else if (st == 3 && !dmem_ready) begin
        if (m_tmo == MEM_TIMEOUT) begin m_err = 1'b1; m_halted = 1'b1; end
        else m_tmo++;
      end else if (m_cls == C_HALT) begin
        m_halted = 1'b1;
      end else if (m_idx == path_len[m_cls] - 1) begin
        m_ret++; m_idx = 0;
      end else begin
        m_idx++;
        if (path_stg[m_cls][m_idx] == 3) m_tmo = 0;
      end
    end
  end

  // ---------------- directed instruction runner -----------------------------
  int         lat, wr_cnt, wr_at;
  bit         f_we, f_dreq, f_pcen, f_pcsel, ok_done;
  logic [2:0] seq [0:63];

  // Entered at posedge+1 in FETCH; runs one instruction until FETCH/HALTED.
  // dwait = number of MEM cycles with dmem_ready low before it is raised.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic cf,
                       input int dwait);
    int mc;
    mc = 0; lat = 0; wr_cnt = 0; wr_at = -1;
    f_we = 0; f_dreq = 0; f_pcen = 0; f_pcsel = 0; ok_done = 0;
    opcode = op; fnction = fn; cond_flag = cf; imem_ready = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 60; k++) begin
      #1;
      seq[lat] = stage;
      if (dmem_we)  f_we = 1;
      if (dmem_req) f_dreq = 1;
      if (rf_wr_en) begin wr_cnt++; wr_at = lat + 1; end
      if (pc_en)    begin f_pcen = 1; f_pcsel = pc_sel; end
      lat++;
      @(posedge clk); #1;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      if (stage == 3'd0 || stage == 3'd7) begin ok_done = 1; break; end
      if (stage == 3'd3) begin dmem_ready = (mc >= dwait); mc++; end
    end
    if (!ok_done) chk("instr_cycle_bound", 0, 1);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stage", stage, 0);
    chk("rst_imem_req", imem_req, 1);
    chk("rst_ir_en", ir_en, 0);
    chk("rst_retired", retired, 0);
    chk("rst_err", err, 0);
    chk("rst_halted", halted, 0);
    rst_n = 1'b1;

    // add: 000,001,010,100 then back to 000
    instr(6'h00, 6'h20, 1'b0, 0);
    chk("add_lat", lat, 4);
    chk("add_s0", seq[0], 0); chk("add_s1", seq[1], 1);
    chk("add_s2", seq[2], 2); chk("add_s3", seq[3], 4);
    chk("add_wr_cnt", wr_cnt, 1); chk("add_wr_at", wr_at, 4);
    chk("add_retired", retired, 1);

    // lw with 3 waiting MEM cycles
    instr(6'h23, 6'h00, 1'b0, 3);
    chk("lw_lat", lat, 8);
    chk("lw_mem_first", seq[3], 3); chk("lw_mem_last", seq[6], 3);
    chk("lw_wb", seq[7], 4); chk("lw_we", f_we, 0);
    chk("lw_retired", retired, 2);

    // sw that never completes -> timeout halt
    instr(6'h2B, 6'h00, 1'b0, 1000);
    chk("sw_lat", lat, 19);
    chk("sw_stage", stage, 7); chk("sw_err", err, 1); chk("sw_halted", halted, 1);
    chk("sw_we", f_we, 1); chk("sw_retired", retired, 2);
    resume = 1'b1; step(); resume = 1'b0;
    chk("sw_resume_stage", stage, 0); chk("sw_err_sticky", err, 1);

    // branches and jump
    instr(6'h11, 6'h00, 1'b1, 0);
    chk("br1_lat", lat, 3); chk("br1_pcen", f_pcen, 1); chk("br1_pcsel", f_pcsel, 1);
    chk("br1_wr", wr_cnt, 0); chk("br1_dreq", f_dreq, 0);
    instr(6'h11, 6'h00, 1'b0, 0);
    chk("br0_pcen", f_pcen, 1); chk("br0_pcsel", f_pcsel, 0);
    chk("br0_wr", wr_cnt, 0); chk("br0_dreq", f_dreq, 0);
    instr(6'h02, 6'h00, 1'b0, 0);
    chk("jr_lat", lat, 3); chk("jr_pcsel", f_pcsel, 1);
    instr(6'h00, 6'h00, 1'b0, 0);
    chk("nop_lat", lat, 2); chk("nop_retired", retired, 6);

    // halt, resume under stall, then real resume
    instr(6'h3F, 6'h00, 1'b0, 0);
    chk("halt_lat", lat, 2); chk("halt_stage", stage, 7); chk("halt_retired", retired, 6);
    resume = 1'b1; stall = 1'b1; step();
    chk("halt_stalled_resume", stage, 7);
    stall = 1'b0; step(); resume = 1'b0;
    chk("halt_resume", stage, 0);

    // stall 5 cycles in EXEC of an ALU op
    opcode = 6'h00; fnction = 6'h21; imem_ready = 1'b1; step();
    imem_ready = 1'b0; step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_stage", stage, 2); chk("stall_alu_en", alu_en, 0);
      step();
    end
    stall = 1'b0;
    chk("stall_release_stage", stage, 2);
    step(); chk("stall_wb", stage, 4);
    step(); chk("stall_done", stage, 0); chk("stall_retired", retired, 7);

    // reset pulse during MEM of a lw
    opcode = 6'h23; fnction = 6'h00; imem_ready = 1'b1; step();
    imem_ready = 1'b0; step(); step();
    chk("rstmem_in_mem", stage, 3);
    rst_n = 1'b0; #1;
    chk("rstmem_stage", stage, 0); chk("rstmem_pc_en", pc_en, 0);
    chk("rstmem_retired", retired, 0);
    step(); rst_n = 1'b1;
    chk("rstmem_after", stage, 0);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0: opcode = 6'h00;
        1: opcode = 6'h08;
        2: opcode = 6'h0C;
        3: opcode = 6'h23;
        4: opcode = 6'h2B;
        5: opcode = 6'h11;
        6: opcode = 6'h02;
        7: opcode = 6'h3F;
        8: opcode = 6'h0D;
        default: opcode = 6'($urandom);
      endcase
      fnction    = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom);
      imem_ready = ($urandom_range(0, 3) != 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      cond_flag  = 1'($urandom);
      stall      = ($urandom_range(0, 7) == 0);
      resume     = ($urandom_range(0, 3) == 0);
      step();
    end
    stall = 1'b0; resume = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
